// File: rtl/leds_ctrl_pkg.sv
// leds_ctrl_pkg: mode encodings, mode sequencing and LED pattern decode for leds_ctrl
package leds_ctrl_pkg;
  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_ON    = 3'd1,
    M_SLOW  = 3'd2,
    M_FAST  = 3'd3,
    M_CHASE = 3'd4
  } mode_e;
  localparam int N_MODES = 5;
  // Encodings past CHASE behave as OFF, so they advance to ON.
  function automatic mode_e next_mode(input mode_e m);
    return int'(m) < N_MODES - 1 ? mode_e'(m + 3'd1) :
           int'(m) == N_MODES - 1 ? M_OFF : M_ON;
  endfunction
  function automatic logic [1:0] led_decode(input mode_e m, input logic [2:0] p);
    return m == M_ON    ? 2'b11 :
           m == M_SLOW  ? {2{~p[2]}} :
           m == M_FAST  ? {2{~p[0]}} :
           m == M_CHASE ? (p[1] ? 2'b10 : 2'b01) : 2'b00;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-count debouncer and press pulse for one raw button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic          r_s1, r_s2, r_lvl, r_lvl_d, r_press, r_arm;
  logic [1:0]    r_vld;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_inc;
  assign w_inc = r_cnt + CW'(1);
  assign level = r_lvl;
  assign press = r_press;
  // r_arm stays low until the synchronized input is seen released after reset,
  // so a button held through reset never reports a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_press <= 1'b0;
      r_arm   <= 1'b0;
      r_vld   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_s1    <= in;
      r_s2    <= r_s1;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_s2) r_arm <= 1'b1;
      if (r_s2 == r_lvl) r_cnt <= '0;
      else if (w_inc == C_MAX) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else r_cnt <= w_inc;
      r_lvl_d <= r_lvl;
      r_press <= r_lvl & ~r_lvl_d & r_arm;
    end
  end
endmodule

// File: rtl/leds_ctrl.sv
// leds_ctrl: debounced MODE/PAUSE buttons driving a mode FSM, tick prescaler and registered LED patterns
module leds_ctrl
  import leds_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TICK_CYCLES     = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] but,
  output logic [1:0] led,
  output logic [2:0] mode,
  output logic       paused
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] P_MAX = PW'(TICK_CYCLES - 1);
  logic [1:0]    w_press;
  logic          w_tick;
  mode_e         r_mode;
  logic          r_paused;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_p;
  logic [1:0]    r_led;
  for (genvar i = 0; i < 2; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .in    (but[i]),
      .level (),
      .press (w_press[i])
    );
  end
  assign w_tick = r_pre == P_MAX;
  assign led    = r_led;
  assign mode   = r_mode;
  assign paused = r_paused;
  // A MODE press wins over a simultaneous PAUSE press and always leaves the pattern running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= M_OFF;
      r_paused <= 1'b0;
      r_pre    <= '0;
      r_p      <= '0;
      r_led    <= '0;
    end else begin
      r_led <= led_decode(r_mode, r_p);
      if (w_press[0]) begin
        r_mode   <= next_mode(r_mode);
        r_paused <= 1'b0;
        r_pre    <= '0;
        r_p      <= '0;
      end else begin
        if (w_press[1]) r_paused <= ~r_paused;
        if (!r_paused) begin
          r_pre <= w_tick ? '0 : r_pre + PW'(1);
          if (w_tick) r_p <= r_p + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_leds_ctrl.sv
// tb_leds_ctrl: directed, table-driven bench for leds_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=3
module tb_leds_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] but = 2'b11;
  logic [1:0] led;
  logic [2:0] mode;
  logic       paused;
  int n_chk = 0;
  int n_err = 0;
  int bad, waited;
  logic [1:0] frozen, nfrozen;
  typedef struct {
    logic [2:0] mode;
    logic [1:0] led;
  } vec_t;
  vec_t tbl[5];

  leds_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .but    (but),
    .led    (led),
    .mode   (mode),
    .paused (paused)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive buttons; returns 7 edges later, when the press has taken effect.
  task automatic push(input logic [1:0] b);
    but = b;
    step(7);
  endtask

  task automatic release_btn();
    step(1);
    but = 2'b00;
  endtask

  // LED after the j-th edge following the first post-mode-change LED update.
  function automatic logic [1:0] exp_led(input int m, input int j);
    logic [2:0] p;
    p = 3'((j / 3) % 8);
    return m == 1 ? 2'b11 : m == 2 ? {2{~p[2]}} : m == 3 ? {2{~p[0]}} :
           m == 4 ? (p[1] ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  task automatic sample(input int m, input int n);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("pattern_m%0d_j%0d", m, j), led, exp_led(m, j));
      step(1);
    end
  endtask

  initial begin
    tbl[0] = '{3'd1, 2'b11};
    tbl[1] = '{3'd2, 2'b11};
    tbl[2] = '{3'd3, 2'b11};
    tbl[3] = '{3'd4, 2'b01};
    tbl[4] = '{3'd0, 2'b00};

    // Reset with both buttons held, then keep holding
    step(2);
    chk("rst_led", led, 0);
    chk("rst_mode", mode, 0);
    chk("rst_paused", paused, 0);
    rst = 1'b0;
    step(20);
    chk("held_mode", mode, 0);
    chk("held_paused", paused, 0);
    but = 2'b00;
    step(10);

    // Mode stepping with exact latency
    for (int i = 0; i < 5; i++) begin
      but = 2'b01;
      step(6);
      chk($sformatf("step%0d_early", i), mode, i == 0 ? 0 : int'(tbl[i-1].mode));
      step(1);
      chk($sformatf("step%0d_mode", i), mode, tbl[i].mode);
      chk($sformatf("step%0d_paused", i), paused, 0);
      step(1);
      chk($sformatf("step%0d_led", i), led, tbl[i].led);
      but = 2'b00;
      step(8);
    end

    // Glitch of two cycles
    but = 2'b01;
    step(2);
    but = 2'b00;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (mode != 3'd0) bad++;
    end
    chk("glitch_mode_changes", bad, 0);

    // Patterns ON, SLOW, FAST
    push(2'b01);
    chk("to_on", mode, 1);
    release_btn();
    sample(1, 16);
    push(2'b01);
    chk("to_slow", mode, 2);
    release_btn();
    sample(2, 48);
    push(2'b01);
    chk("to_fast", mode, 3);
    release_btn();
    sample(3, 24);

    // Pause and resume in FAST
    push(2'b10);
    chk("pause_set", paused, 1);
    release_btn();
    frozen = led;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (led != frozen) bad++;
    end
    chk("pause_frozen_changes", bad, 0);
    chk("pause_still", paused, 1);
    chk("pause_mode", mode, 3);
    push(2'b10);
    chk("resume_paused", paused, 0);
    release_btn();
    waited = 0;
    while (led == frozen && waited < 8) begin
      step(1);
      waited++;
    end
    chk("resume_within3", int'(waited <= 3), 1);
    nfrozen = ~frozen;
    chk("resume_phase", led, nfrozen);
    step(10);

    // CHASE pattern
    push(2'b01);
    chk("to_chase", mode, 4);
    release_btn();
    sample(4, 24);

    // Back to SLOW, pause, then both buttons together
    push(2'b01);
    chk("wrap_off", mode, 0);
    release_btn();
    step(16);
    push(2'b01);
    chk("wrap_on", mode, 1);
    release_btn();
    step(16);
    push(2'b01);
    chk("wrap_slow", mode, 2);
    release_btn();
    step(16);
    push(2'b10);
    chk("slow_paused", paused, 1);
    release_btn();
    step(16);
    push(2'b11);
    chk("both_mode", mode, 3);
    chk("both_paused", paused, 0);
    release_btn();
    step(16);

    // Reset mid-CHASE, then a fresh press still works
    push(2'b01);
    chk("pre_rst_mode", mode, 4);
    release_btn();
    step(7);
    rst = 1'b1;
    step(1);
    chk("midrst_led", led, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_paused", paused, 0);
    rst = 1'b0;
    step(5);
    push(2'b01);
    chk("post_rst_press", mode, 1);
    release_btn();
    step(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
